// File: rtl/linalg_pkg.sv
// Shared definitions for the linalg datapath blocks: element width,
// transpose mode encoding and a counter-width helper.
package linalg_pkg;

    localparam int FP32_W = 32;

    typedef enum logic {PASS = 1'b0, TRANSPOSE = 1'b1} tr_mode_t;

    // $clog2 that never returns 0, so a single-entry range still gets a 1-bit counter.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mat_bank_ram.sv
// One matrix bank: M*N words, synchronous write at (row,col), combinational
// read at (row,col). Kept asynchronous-read so it maps onto distributed RAM.
module mat_bank_ram
    import linalg_pkg::*;
#(
    parameter int M  = 2,
    parameter int N  = 3,
    parameter int W  = FP32_W,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [CW-1:0] wr_row_i,
    input  logic [CW-1:0] wr_col_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [CW-1:0] rd_row_i,
    input  logic [CW-1:0] rd_col_i,
    output logic [W-1:0]  rd_data_o
);

    // Flat storage rounded up to a power of two so the address width matches the depth exactly.
    localparam int AW = clog2_min1(M * N);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign wr_addr = AW'(wr_row_i) * AW'(N) + AW'(wr_col_i);
    assign rd_addr = AW'(rd_row_i) * AW'(N) + AW'(rd_col_i);

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr];

endmodule

// File: rtl/mat_transpose_stream.sv
// Streaming ping-pong matrix transpose: one bank loads row-major while the
// other drains either transposed or unchanged, per the mode latched at load.
module mat_transpose_stream
    import linalg_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 3,
    parameter int W = FP32_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_transpose,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_transposed
);

    localparam int CW = clog2_min1((M > N) ? M : N);
    localparam logic [CW-1:0] M_LAST = CW'(M - 1);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);

    logic          wr_bank_q, wr_bank_d;
    logic [CW-1:0] wr_r_q, wr_r_d, wr_c_q, wr_c_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    tmode_q, tmode_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] o_q, o_d, i_q, i_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          out_tr_q, out_tr_d;

    logic          wr_fire, wr_last, load, rd_last;
    tr_mode_t      rd_mode;
    logic [CW-1:0] in_lim, out_lim, rd_row, rd_col;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  bank_rd_data [2];

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = (wr_r_q == M_LAST) && (wr_c_q == N_LAST);

    // Transposed drain walks columns outer / rows inner; pass-through walks rows outer.
    assign rd_mode  = tr_mode_t'(tmode_q[rd_bank_q]);
    assign in_lim   = (rd_mode == TRANSPOSE) ? M_LAST : N_LAST;
    assign out_lim  = (rd_mode == TRANSPOSE) ? N_LAST : M_LAST;
    assign rd_row   = (rd_mode == TRANSPOSE) ? i_q : o_q;
    assign rd_col   = (rd_mode == TRANSPOSE) ? o_q : i_q;
    assign rd_last  = (i_q == in_lim) && (o_q == out_lim);
    assign load     = (!out_valid_q || out_ready) && full_q[rd_bank_q];
    assign rd_data  = bank_rd_data[rd_bank_q];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        mat_bank_ram #(.M(M), .N(N), .W(W), .CW(CW)) u_bank (
            .clk       (clk),
            .we_i      (wr_fire && (wr_bank_q == 1'(gi))),
            .wr_row_i  (wr_r_q),
            .wr_col_i  (wr_c_q),
            .wr_data_i (in_data),
            .rd_row_i  (rd_row),
            .rd_col_i  (rd_col),
            .rd_data_o (bank_rd_data[gi])
        );
    end

    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_r_d      = wr_r_q;
        wr_c_d      = wr_c_q;
        full_d      = full_q;
        tmode_d     = tmode_q;
        rd_bank_d   = rd_bank_q;
        o_d         = o_q;
        i_d         = i_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_tr_d    = out_tr_q;

        if (wr_fire) begin
            if ((wr_r_q == '0) && (wr_c_q == '0)) begin
                tmode_d[wr_bank_q] = in_transpose;
            end
            if (wr_c_q == N_LAST) begin
                wr_c_d = '0;
                wr_r_d = (wr_r_q == M_LAST) ? '0 : wr_r_q + CW'(1);
            end else begin
                wr_c_d = wr_c_q + CW'(1);
            end
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Write completion and read completion always target different banks.
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
            out_last_d  = rd_last;
            out_tr_d    = rd_mode;
            if (i_q == in_lim) begin
                i_d = '0;
                o_d = (o_q == out_lim) ? '0 : o_q + CW'(1);
            end else begin
                i_d = i_q + CW'(1);
            end
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_r_q      <= '0;
            wr_c_q      <= '0;
            full_q      <= '0;
            tmode_q     <= '0;
            rd_bank_q   <= 1'b0;
            o_q         <= '0;
            i_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_tr_q    <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_r_q      <= wr_r_d;
            wr_c_q      <= wr_c_d;
            full_q      <= full_d;
            tmode_q     <= tmode_d;
            rd_bank_q   <= rd_bank_d;
            o_q         <= o_d;
            i_q         <= i_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_tr_q    <= out_tr_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_last       = out_last_q;
    assign out_transposed = out_tr_q;

endmodule
